// File: rtl/spi_xip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_xip_pkg
// Description : Shared definitions for the SPI XIP read cache. Holds the
//               controller state encoding, the default flash window bounds
//               and a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_xip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic [31:0] c_FLASH_BASE = 32'h3000_0000;
    localparam logic [31:0] c_FLASH_END  = 32'h3fff_ffff;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hffff_ffff) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xip_tag_array.sv
`default_nettype none
// ============================================================================
// Module      : xip_tag_array
// Description : Direct-mapped line store, one 32-bit word per line. Valid
//               bits are reset and cleared by a level flush; tags and data
//               are plain storage. Lookup is purely combinational.
// Revision    : 1.0 - initial release
// Ports       : clk, reset          - clock, async active-high reset
//               lookup_idx/tag      - line index and tag to compare
//               lookup_hit/data     - valid && tag match, and line data
//               fill_en/idx/tag/data- single write port for line fills
//               flush               - level; clears every valid bit
// ============================================================================
module xip_tag_array #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] lookup_idx,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_hit,
    output logic [31:0]      lookup_data,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic [31:0]      fill_data,
    input  logic             flush
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Flush has priority over a coincident fill so the line ends up invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (fill_en) begin
            r_valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en && !flush) begin
            r_tag[fill_idx]  <= fill_tag;
            r_data[fill_idx] <= fill_data;
        end
    end

    assign lookup_hit  = r_valid[lookup_idx] && (r_tag[lookup_idx] == lookup_tag);
    assign lookup_data = r_data[lookup_idx];

endmodule
`default_nettype wire

// File: rtl/spi_xip_cache.sv
`default_nettype none
// ============================================================================
// Module      : spi_xip_cache
// Description : Read buffer between an upstream APB slave port and the SPI
//               flash APB bridge. Flash-window reads that hit return with
//               zero wait states; misses issue one downstream read and fill
//               the line. Other addresses pass through uncached and flash
//               writes are answered locally with an error.
// Revision    : 1.0 - initial release
// Ports       : clk, reset           - clock, async active-high reset
//               in_p*                - upstream APB slave interface
//               out_p*               - downstream APB master interface
//               flush                - level; invalidates every line
//               hit_count/miss_count - saturating flash read statistics
// ============================================================================
module spi_xip_cache
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE = c_FLASH_BASE,
    parameter logic [31:0] FLASH_END  = c_FLASH_END,
    parameter int          LINES      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 26 - IDX_W;

    state_t      r_state;
    state_t      w_next_state;

    // Latched request, driven onto the downstream port.
    logic [31:0] r_addr;
    logic [2:0]  r_prot;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic        r_fill_req;
    logic        r_flush_seen;

    // Downstream response capture.
    logic [31:0] r_rdata;
    logic        r_slverr;

    logic [31:0] r_hits;
    logic [31:0] r_misses;

    logic             w_req;
    logic             w_is_flash;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_lookup_hit;
    logic [31:0]      w_lookup_data;
    logic             w_hit;
    logic             w_fill_en;
    logic             w_latch;
    logic             w_hit_inc;
    logic             w_miss_inc;

    assign w_req      = (r_state == ST_IDLE) && in_psel && in_penable;
    assign w_is_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
    assign w_idx      = in_paddr[IDX_W+1:2];
    assign w_tag      = in_paddr[27:IDX_W+2];
    // A flush in the decode cycle beats a would-be hit.
    assign w_hit      = w_lookup_hit && !flush;

    // The fill is dropped if a flush was seen at any point since SETUP,
    // including the completing cycle itself.
    assign w_fill_en  = (r_state == ST_ACCESS) && out_pready && r_fill_req &&
                        !out_pslverr && !r_flush_seen && !flush;

    xip_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk         (clk),
        .reset       (reset),
        .lookup_idx  (w_idx),
        .lookup_tag  (w_tag),
        .lookup_hit  (w_lookup_hit),
        .lookup_data (w_lookup_data),
        .fill_en     (w_fill_en),
        .fill_idx    (r_addr[IDX_W+1:2]),
        .fill_tag    (r_addr[27:IDX_W+2]),
        .fill_data   (out_prdata),
        .flush       (flush)
    );

    always_comb begin
        w_next_state = r_state;
        in_pready    = 1'b0;
        in_prdata    = 32'd0;
        in_pslverr   = 1'b0;
        w_latch      = 1'b0;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_is_flash && in_pwrite) begin
                        w_next_state = ST_ERR;
                    end else if (w_is_flash && w_hit) begin
                        in_pready = 1'b1;
                        in_prdata = w_lookup_data;
                        w_hit_inc = 1'b1;
                    end else begin
                        w_miss_inc   = w_is_flash;
                        w_latch      = 1'b1;
                        w_next_state = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                w_next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (out_pready) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                in_pready    = 1'b1;
                in_prdata    = r_rdata;
                in_pslverr   = r_slverr;
                w_next_state = ST_IDLE;
            end
            ST_ERR: begin
                in_pready    = 1'b1;
                in_pslverr   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= 32'd0;
            r_prot       <= 3'd0;
            r_write      <= 1'b0;
            r_wdata      <= 32'd0;
            r_strb       <= 4'd0;
            r_fill_req   <= 1'b0;
            r_flush_seen <= 1'b0;
            r_rdata      <= 32'd0;
            r_slverr     <= 1'b0;
            r_hits       <= 32'd0;
            r_misses     <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_latch) begin
                r_addr       <= {in_paddr[31:2], 2'b00};
                r_prot       <= in_pprot;
                r_write      <= in_pwrite;
                r_wdata      <= in_pwdata;
                r_strb       <= in_pstrb;
                r_fill_req   <= w_is_flash;
                r_flush_seen <= 1'b0;
            end else if (((r_state == ST_SETUP) || (r_state == ST_ACCESS)) && flush) begin
                r_flush_seen <= 1'b1;
            end
            if ((r_state == ST_ACCESS) && out_pready) begin
                r_rdata  <= out_prdata;
                r_slverr <= out_pslverr;
            end
            if (w_hit_inc) begin
                r_hits <= sat_inc(r_hits);
            end
            if (w_miss_inc) begin
                r_misses <= sat_inc(r_misses);
            end
        end
    end

    assign out_psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign out_penable = (r_state == ST_ACCESS);
    assign out_paddr   = r_addr;
    assign out_pprot   = r_prot;
    assign out_pwrite  = r_write;
    assign out_pwdata  = r_wdata;
    assign out_pstrb   = r_strb;
    assign hit_count   = r_hits;
    assign miss_count  = r_misses;

endmodule
`default_nettype wire

// File: tb/tb_spi_xip_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xip_cache
// Description : Self-checking bench for spi_xip_cache. A simple downstream
//               APB slave with programmable wait states/error sits below the
//               DUT; a line-level cache model predicts every upstream result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xip_cache;

    localparam int          LINES = 16;
    localparam logic [31:0] FBASE = 32'h3000_0000;
    localparam logic [31:0] FEND  = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_paddr;
    logic        in_psel, in_penable, in_pwrite;
    logic [2:0]  in_pprot;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready, in_pslverr;
    logic [31:0] in_prdata;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    logic [2:0]  out_pprot;
    logic [3:0]  out_pstrb;
    logic        flush;
    logic [31:0] hit_count, miss_count;

    spi_xip_cache #(.FLASH_BASE(FBASE), .FLASH_END(FEND), .LINES(LINES)) dut (
        .clk(clk), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
        .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
        .in_pslverr(in_pslverr),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr),
        .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ---------------- downstream environment ----------------
    logic [31:0] mem [logic [31:0]];
    int unsigned ds_waits;
    bit          ds_err;
    int          ds_count;
    logic [31:0] ds_addr, ds_wdata;
    logic        ds_write;
    logic [3:0]  ds_strb;
    logic [2:0]  ds_prot;

    function automatic logic [31:0] ds_value(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    initial begin
        int unsigned cnt;
        cnt = 0;
        out_pready = 1'b0; out_prdata = 32'd0; out_pslverr = 1'b0;
        ds_count = 0;
        ds_addr = 0; ds_wdata = 0; ds_write = 0; ds_strb = 0; ds_prot = 0;
        forever begin
            @(posedge clk); #1;
            out_pready = 1'b0; out_prdata = 32'd0; out_pslverr = 1'b0;
            if (out_psel && !out_penable) begin
                ds_count++;
                ds_addr  = out_paddr;  ds_write = out_pwrite; ds_wdata = out_pwdata;
                ds_strb  = out_pstrb;  ds_prot  = out_pprot;
                cnt = ds_waits;
            end else if (out_psel && out_penable) begin
                if (cnt == 0) begin
                    out_pready  = 1'b1;
                    out_pslverr = ds_err;
                    if (out_pwrite) begin
                        if (!ds_err) mem[out_paddr] = out_pwdata;
                    end else begin
                        out_prdata = ds_value(out_paddr);
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- reference model: one word per line ----------------
    bit          m_valid [LINES];
    logic [31:0] m_addr  [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] m_hits, m_misses;

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    function automatic logic [31:0] bump(input logic [31:0] v);
        return (v == 32'hffff_ffff) ? v : v + 1;
    endfunction

    // fmode: 0 none, 1 flush during the decode cycle, 2 flush for one cycle in ACCESS
    task automatic do_txn(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input int unsigned w, input bit err, input int fmode);
        logic [31:0] aligned, exp_rdata, got_rdata;
        bit          isf, exp_ds, exp_err, got_err, done, fdone;
        int          idx, exp_waits, waits, ds_before;
        aligned = addr & ~32'd3;
        isf     = (addr >= FBASE) && (addr <= FEND);
        idx     = int'((aligned >> 2) % LINES);
        exp_ds  = 1'b0;
        exp_err = 1'b0;
        exp_rdata = 32'd0;
        exp_waits = 0;
        if (fmode == 1) model_clear();
        if (isf && wr) begin
            exp_err = 1'b1; exp_waits = 1;
        end else if (isf && m_valid[idx] && m_addr[idx] == aligned) begin
            exp_rdata = m_data[idx];
            m_hits    = bump(m_hits);
        end else begin
            exp_ds    = 1'b1;
            exp_err   = err;
            exp_waits = int'(w) + 3;
            exp_rdata = wr ? 32'd0 : ds_value(aligned);
            if (fmode == 2) model_clear();
            if (isf) begin
                m_misses = bump(m_misses);
                if (!err && fmode != 2) begin
                    m_valid[idx] = 1'b1; m_addr[idx] = aligned; m_data[idx] = exp_rdata;
                end
            end
        end

        ds_waits = w; ds_err = err; ds_before = ds_count;
        @(posedge clk); #1;
        in_psel = 1'b1; in_penable = 1'b0; in_paddr = addr; in_pwrite = wr;
        in_pwdata = wdata; in_pstrb = strb; in_pprot = prot;
        @(posedge clk); #1;
        in_penable = 1'b1;
        if (fmode == 1) flush = 1'b1;
        waits = 0; done = 1'b0; fdone = 1'b0;
        got_rdata = 32'd0; got_err = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_pready) begin
                got_rdata = in_prdata; got_err = in_pslverr; done = 1'b1;
            end else begin
                waits++;
                if (waits == 1) check_eq("prdata_when_not_ready", in_prdata, 32'd0);
            end
            @(posedge clk); #1;
            flush = 1'b0;
            if (fmode == 2 && !fdone && out_penable) begin
                flush = 1'b1; fdone = 1'b1;
            end
        end
        flush = 1'b0; in_psel = 1'b0; in_penable = 1'b0;
        if (!done) check_eq("ready_timeout", 32'd0, 32'd1);
        check_eq("rdata", got_rdata, exp_rdata);
        check_eq("pslverr", {31'd0, got_err}, {31'd0, exp_err});
        check_eq("wait_states", waits, exp_waits);
        check_eq("ds_accesses", ds_count - ds_before, exp_ds ? 32'd1 : 32'd0);
        if (exp_ds) begin
            check_eq("ds_addr", ds_addr, aligned);
            check_eq("ds_write_prot", {28'd0, ds_write, ds_prot}, {28'd0, wr, prot});
            if (wr) begin
                check_eq("ds_wdata", ds_wdata, wdata);
                check_eq("ds_strb", {28'd0, ds_strb}, {28'd0, strb});
            end
        end
        check_eq("hit_count", hit_count, m_hits);
        check_eq("miss_count", miss_count, m_misses);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctl"}, {23'd0, out_psel, out_penable, out_pwrite, in_pready, in_pslverr,
                                 out_pprot[0], out_pprot[1], out_pprot[2], |out_pstrb}, 32'd0);
        check_eq({tag, "_paddr"}, out_paddr, 32'd0);
        check_eq({tag, "_pwdata"}, out_pwdata, 32'd0);
        check_eq({tag, "_prdata"}, in_prdata, 32'd0);
        check_eq({tag, "_hits"}, hit_count, 32'd0);
        check_eq({tag, "_misses"}, miss_count, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          saw_access;
        reset = 1'b1; flush = 1'b0;
        in_paddr = 0; in_psel = 0; in_penable = 0; in_pprot = 0;
        in_pwrite = 0; in_pwdata = 0; in_pstrb = 0;
        ds_waits = 0; ds_err = 0;
        model_clear(); m_hits = 0; m_misses = 0;
        mem[32'h3000_0010] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;

        // cold miss, then hit, then conflict replacement
        do_txn(32'h3000_0010, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        do_txn(32'h3000_0010, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        do_txn(32'h3000_0050, 0, 0, 4'hf, 3'd1, 1, 0, 0);
        do_txn(32'h3000_0010, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        // flash write rejected, non-flash write forwarded
        do_txn(32'h3000_0000, 1, 32'h1234_5678, 4'hf, 3'd0, 0, 0, 0);
        do_txn(32'h1000_1000, 1, 32'hA5A5_5A5A, 4'b0101, 3'b010, 2, 0, 0);
        do_txn(32'h1000_1000, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        // flush during ACCESS with 5 downstream waits, and flush against a hit
        do_txn(32'h3000_0020, 0, 0, 4'hf, 3'd0, 5, 0, 2);
        do_txn(32'h3000_0020, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        do_txn(32'h3000_0020, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        do_txn(32'h3000_0020, 0, 0, 4'hf, 3'd0, 0, 0, 1);
        // downstream error on a miss leaves the line invalid
        do_txn(32'h3000_0030, 0, 0, 4'hf, 3'd0, 1, 1, 0);
        do_txn(32'h3000_0030, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        // window edges
        do_txn(32'h2fff_fffc, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        do_txn(32'h3fff_fffe, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        do_txn(32'h3fff_fffc, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        do_txn(32'h4000_0000, 0, 0, 4'hf, 3'd0, 0, 0, 0);

        // reset asserted while the DUT is in ACCESS
        ds_waits = 5; ds_err = 0;
        @(posedge clk); #1;
        in_psel = 1; in_penable = 0; in_paddr = 32'h3000_0044; in_pwrite = 0;
        @(posedge clk); #1;
        in_penable = 1;
        saw_access = 1'b0;
        for (int c = 0; c < 20 && !saw_access; c++) begin
            @(posedge clk); #1;
            saw_access = out_penable;
        end
        check_eq("reached_access", {31'd0, saw_access}, 32'd1);
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        in_psel = 0; in_penable = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear(); m_hits = 0; m_misses = 0;
        do_txn(32'h3fff_fffc, 0, 0, 4'hf, 3'd0, 0, 0, 0);
        do_txn(32'h3fff_fffc, 0, 0, 4'hf, 3'd0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            int unsigned sel;
            int          fm;
            sel = $urandom_range(0, 9);
            if (sel <= 6) begin
                a = FBASE + ($urandom_range(0, 3) << 6) + ($urandom_range(0, LINES - 1) << 2)
                    + $urandom_range(0, 3);
            end else if (sel == 7) begin
                case ($urandom_range(0, 3))
                    0: a = 32'h2fff_fffc;
                    1: a = 32'h3fff_fffc;
                    2: a = 32'h4000_0000;
                    default: a = 32'h3000_0000;
                endcase
            end else begin
                a = 32'h1000_0000 + ($urandom & 32'h0000_0ffc);
            end
            fm = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 2)) : 0;
            do_txn(a, ($urandom_range(0, 3) == 0), $urandom, 4'($urandom), 3'($urandom),
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0), fm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
